// File: rtl/store_queue_unit.sv
// Store queue: decodes sized stores into lane enables and aligned data, traps bad stores,
// and buffers legal ones in a FIFO that drains over a req/gnt memory port with fence support.
module store_queue_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [2:0]                 st_funct3,
    input  logic [XLEN-1:0]            st_addr,
    input  logic [XLEN-1:0]            st_data,
    output logic                       fault_valid,
    output logic                       fault_misaligned,
    output logic [XLEN-1:0]            fault_addr,
    output logic                       mem_req,
    input  logic                       mem_gnt,
    output logic [XLEN-1:0]            mem_addr,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [XLEN/8-1:0]          mem_we,
    input  logic [XLEN-1:0]            ld_addr,
    output logic                       ld_conflict,
    input  logic                       fence_req,
    output logic                       fence_done,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(LANES);
    localparam int unsigned PTRW  = $clog2(DEPTH);
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {RUN, FENCE, DONE} state_t;

    state_t              state, state_next;
    logic [PTRW-1:0]     rd_ptr, wr_ptr, rel;
    logic [XLEN-1:0]     addr_q [DEPTH];
    logic [XLEN-1:0]     data_q [DEPTH];
    logic [LANES-1:0]    we_q   [DEPTH];

    logic [3:0]          size;
    logic                illegal, misaligned;
    logic [OFFW-1:0]     off;
    logic [LANES-1:0]    size_mask, enq_we;
    logic [XLEN-1:0]     masked, enq_data, enq_addr, ld_aligned;
    logic                accept, push, pop;

    // Size decode, alignment check and lane placement of the incoming store
    always_comb begin
        size    = 4'd1;
        illegal = 1'b0;
        case (st_funct3)
            3'b000:  size = 4'd1;
            3'b001:  size = 4'd2;
            3'b010:  size = 4'd4;
            3'b011:  if (XLEN == 64) size = 4'd8; else illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
        off        = st_addr[OFFW-1:0];
        misaligned = !illegal && ((off & OFFW'(size - 4'd1)) != '0);
        size_mask  = '0;
        masked     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            size_mask[i]    = (i < 32'(size));
            masked[8*i +: 8] = size_mask[i] ? st_data[8*i +: 8] : 8'h00;
        end
        enq_we   = size_mask << off;
        enq_data = masked << {off, 3'b000};
        enq_addr = st_addr & ~XLEN'(LANES - 1);
    end

    assign st_ready = (state == RUN) && (count < CNTW'(DEPTH));
    assign accept   = st_valid && st_ready;
    assign push     = accept && !illegal && !misaligned;
    assign mem_req  = (count != '0);
    assign pop      = mem_req && mem_gnt;

    assign mem_addr  = addr_q[rd_ptr];
    assign mem_wdata = data_q[rd_ptr];
    assign mem_we    = we_q[rd_ptr];

    // A slot is live when its distance from the head is below the occupancy
    always_comb begin
        ld_aligned  = ld_addr & ~XLEN'(LANES - 1);
        ld_conflict = 1'b0;
        rel         = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel = PTRW'(i) - rd_ptr;
            if ((CNTW'(rel) < count) && (addr_q[i] == ld_aligned)) ld_conflict = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (fence_req) state_next = (count == '0) ? DONE : FENCE;
            FENCE:   if ((count == '0) || ((count == CNTW'(1)) && pop)) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= RUN;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            fault_valid      <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_addr       <= '0;
            fence_done       <= 1'b0;
        end else begin
            state      <= state_next;
            fence_done <= (state_next == DONE);
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            if (push && !pop)      count <= count + CNTW'(1);
            else if (!push && pop) count <= count - CNTW'(1);
            fault_valid <= accept && (illegal || misaligned);
            if (accept && (illegal || misaligned)) begin
                fault_misaligned <= misaligned;
                fault_addr       <= st_addr;
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= enq_addr;
            data_q[wr_ptr] <= enq_data;
            we_q[wr_ptr]   <= enq_we;
        end
    end
endmodule

// File: tb/tb_store_queue_unit.sv
// Bench for store_queue_unit: drives a 32-bit and a 64-bit instance with the same stimulus
// and checks both every cycle against a queue-based model plus hand-computed spot values.
module tb_store_queue_unit;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  we;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid, mem_gnt, fence_req;
    logic [2:0]  st_funct3;
    logic [63:0] st_addr, st_data, ld_addr;

    logic        r32, fv32, fm32, mr32, lc32, fd32;
    logic [31:0] fa32, ma32, md32;
    logic [3:0]  mw32;
    logic [2:0]  c32;
    logic        r64, fv64, fm64, mr64, lc64, fd64;
    logic [63:0] fa64, ma64, md64;
    logic [7:0]  mw64;
    logic [2:0]  c64;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ent_t        q0[$];
    ent_t        q1[$];
    int          st[2]  = '{0, 0};
    bit          fv[2]  = '{0, 0};
    bit          fm[2]  = '{0, 0};
    bit          fdn[2] = '{0, 0};
    logic [63:0] fa[2]  = '{64'h0, 64'h0};

    always #5 clk = ~clk;

    store_queue_unit #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_ready(r32),
        .st_funct3(st_funct3), .st_addr(st_addr[31:0]), .st_data(st_data[31:0]),
        .fault_valid(fv32), .fault_misaligned(fm32), .fault_addr(fa32),
        .mem_req(mr32), .mem_gnt(mem_gnt), .mem_addr(ma32), .mem_wdata(md32), .mem_we(mw32),
        .ld_addr(ld_addr[31:0]), .ld_conflict(lc32), .fence_req(fence_req),
        .fence_done(fd32), .count(c32)
    );

    store_queue_unit #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_ready(r64),
        .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
        .fault_valid(fv64), .fault_misaligned(fm64), .fault_addr(fa64),
        .mem_req(mr64), .mem_gnt(mem_gnt), .mem_addr(ma64), .mem_wdata(md64), .mem_we(mw64),
        .ld_addr(ld_addr), .ld_conflict(lc64), .fence_req(fence_req),
        .fence_done(fd64), .count(c64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // What a store turns into, computed from byte sizes and offsets
    function automatic void decode(input int xl, input logic [2:0] f3, input logic [63:0] a_in,
                                   input logic [63:0] d, output bit ill, output bit mis,
                                   output ent_t e);
        int          lanes, size, off;
        logic [63:0] a, mask;
        lanes = xl / 8;
        a     = (xl == 32) ? (a_in & 64'hFFFF_FFFF) : a_in;
        ill   = 1'b0;
        size  = 1;
        case (f3)
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            3'd3:    if (xl == 64) size = 8; else ill = 1'b1;
            default: ill = 1'b1;
        endcase
        off    = int'(a[2:0]) % lanes;
        mis    = !ill && ((off % size) != 0);
        e.addr = a - 64'(off);
        e.we   = 8'((1 << size) - 1) << off;
        mask   = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        e.data = (d & mask) << (8 * off);
        if (xl == 32) e.data = e.data & 64'hFFFF_FFFF;
    endfunction

    // Model: k=0 is the 32-bit instance, k=1 the 64-bit one; st: 0 run, 1 fence, 2 done
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            for (int k = 0; k < 2; k++) begin
                st[k] = 0; fv[k] = 1'b0; fm[k] = 1'b0; fdn[k] = 1'b0; fa[k] = 64'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int   cnt, nst;
                bit   pop, rdy, acc, ill, mis;
                ent_t e;
                cnt = (k == 0) ? q0.size() : q1.size();
                pop = (cnt != 0) && mem_gnt;
                rdy = (st[k] == 0) && (cnt < DEPTH);
                acc = st_valid && rdy;
                decode((k == 0) ? 32 : 64, st_funct3, st_addr, st_data, ill, mis, e);
                if (pop) begin
                    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
                if (acc && !ill && !mis) begin
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                end
                fv[k] = acc && (ill || mis);
                if (fv[k]) begin
                    fm[k] = mis;
                    fa[k] = (k == 0) ? (st_addr & 64'hFFFF_FFFF) : st_addr;
                end
                nst = st[k];
                case (st[k])
                    0: if (fence_req) nst = (cnt == 0) ? 2 : 1;
                    1: if (cnt - int'(pop) == 0) nst = 2;
                    default: nst = 0;
                endcase
                st[k]  = nst;
                fdn[k] = (nst == 2);
            end
        end
    end

    task automatic cmp_dut(input int k, input string sfx,
                           input logic [63:0] cnt, input logic [63:0] req, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] we, input logic [63:0] rdy,
                           input logic [63:0] fvld, input logic [63:0] fmis, input logic [63:0] fadr,
                           input logic [63:0] fdone, input logic [63:0] lc);
        int          n;
        ent_t        h;
        logic [63:0] la;
        bit          conf;
        n = (k == 0) ? q0.size() : q1.size();
        chk({"count", sfx}, cnt, 64'(n));
        chk({"mem_req", sfx}, req, 64'(n != 0));
        if (n != 0) begin
            h = (k == 0) ? q0[0] : q1[0];
            chk({"mem_addr", sfx}, addr, h.addr);
            chk({"mem_wdata", sfx}, wdata, h.data);
            chk({"mem_we", sfx}, we, 64'(h.we));
        end
        chk({"st_ready", sfx}, rdy, 64'((st[k] == 0) && (n < DEPTH)));
        chk({"fault_valid", sfx}, fvld, 64'(fv[k]));
        if (fv[k]) begin
            chk({"fault_misaligned", sfx}, fmis, 64'(fm[k]));
            chk({"fault_addr", sfx}, fadr, fa[k]);
        end
        chk({"fence_done", sfx}, fdone, 64'(fdn[k]));
        la   = (k == 0) ? (ld_addr & 64'hFFFF_FFFC) : (ld_addr & ~64'h7);
        conf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (((k == 0) ? q0[i].addr : q1[i].addr) == la) conf = 1'b1;
        end
        chk({"ld_conflict", sfx}, lc, 64'(conf));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, "32", 64'(c32), 64'(mr32), 64'(ma32), 64'(md32), 64'(mw32), 64'(r32),
                    64'(fv32), 64'(fm32), 64'(fa32), 64'(fd32), 64'(lc32));
            cmp_dut(1, "64", 64'(c64), 64'(mr64), ma64, md64, 64'(mw64), 64'(r64),
                    64'(fv64), 64'(fm64), fa64, 64'(fd64), 64'(lc64));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; st_valid = 1'b0; st_funct3 = 3'd0; st_addr = '0; st_data = '0;
        mem_gnt = 1'b0; ld_addr = '0; fence_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_count", 64'(c32), 64'd0);
        chk("rst_mem_req", 64'(mr32), 64'd0);
        chk("rst_fault_valid", 64'(fv32), 64'd0);
        chk("rst_fault_addr", 64'(fa32), 64'd0);
        chk("rst_fence_done", 64'(fd64), 64'd0);
        step();
        reset_n = 1'b1;
        step();

        // Byte store lands in the top lane
        mem_gnt = 1'b1;
        store(3'b000, 64'h1003, 64'hAABB_CCDD);
        @(negedge clk);
        chk("sb_mem_req", 64'(mr32), 64'd1);
        chk("sb_mem_addr", 64'(ma32), 64'h1000);
        chk("sb_mem_we", 64'(mw32), 64'b1000);
        chk("sb_mem_wdata", 64'(md32), 64'hDD00_0000);
        chk("sb_mem_we64", 64'(mw64), 64'h08);
        step();
        @(negedge clk);
        chk("sb_drained", 64'(c32), 64'd0);

        // Faults: misaligned half, SD on 32-bit, undefined funct3
        store(3'b001, 64'h2001, 64'h1234);
        @(negedge clk);
        chk("mis_fault_valid", 64'(fv32), 64'd1);
        chk("mis_fault_mis", 64'(fm32), 64'd1);
        chk("mis_fault_addr", 64'(fa32), 64'h2001);
        chk("mis_mem_req", 64'(mr32), 64'd0);
        store(3'b011, 64'h2008, 64'h55);
        @(negedge clk);
        chk("sd32_fault_valid", 64'(fv32), 64'd1);
        chk("sd32_fault_mis", 64'(fm32), 64'd0);
        chk("sd64_no_fault", 64'(fv64), 64'd0);
        store(3'b100, 64'h2000, 64'h0);
        @(negedge clk);
        chk("f3_100_fault64", 64'(fv64), 64'd1);
        chk("f3_100_mis64", 64'(fm64), 64'd0);
        step();
        step();

        // Fill with grant low, probe load conflicts, then stream through with wrap
        mem_gnt = 1'b0;
        store(3'b010, 64'h3004, 64'h1111_1111);
        store(3'b010, 64'h3010, 64'h2222_2222);
        store(3'b010, 64'h3014, 64'h3333_3333);
        store(3'b010, 64'h3018, 64'h4444_4444);
        ld_addr = 64'h3006;
        @(negedge clk);
        chk("full_count", 64'(c32), 64'd4);
        chk("full_ready", 64'(r32), 64'd0);
        chk("ld_conf_hit", 64'(lc32), 64'd1);
        step();
        ld_addr = 64'h3008;
        @(negedge clk);
        chk("ld_conf_miss", 64'(lc32), 64'd0);
        store(3'b010, 64'h4000, 64'h9999_9999);
        mem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) store(3'b010, 64'h5000 + 64'(4 * i), 64'h5000_0000 + 64'(i));
        repeat (6) step();
        @(negedge clk);
        chk("stream_drained", 64'(c32), 64'd0);

        // Fence with two entries pending
        mem_gnt = 1'b0;
        store(3'b010, 64'h6000, 64'h6060_6060);
        store(3'b010, 64'h6004, 64'h6161_6161);
        fence_req = 1'b1;
        step();
        fence_req = 1'b0;
        mem_gnt   = 1'b1;
        @(negedge clk);
        chk("fence_ready0", 64'(r32), 64'd0);
        step();
        step();
        @(negedge clk);
        chk("fence_done_pulse", 64'(fd32), 64'd1);
        chk("fence_count", 64'(c32), 64'd0);
        step();
        @(negedge clk);
        chk("fence_done_clear", 64'(fd32), 64'd0);
        chk("fence_ready1", 64'(r32), 64'd1);
        fence_req = 1'b1;
        step();
        fence_req = 1'b0;
        @(negedge clk);
        chk("fence_empty_done", 64'(fd64), 64'd1);
        step();

        // Reset with entries queued
        mem_gnt = 1'b0;
        store(3'b010, 64'h7000, 64'h7);
        store(3'b010, 64'h7004, 64'h8);
        store(3'b010, 64'h7008, 64'h9);
        @(negedge clk);
        chk("pre_rst_count", 64'(c32), 64'd3);
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_count32", 64'(c32), 64'd0);
        chk("midrst_req32", 64'(mr32), 64'd0);
        chk("midrst_count64", 64'(c64), 64'd0);
        chk("midrst_req64", 64'(mr64), 64'd0);
        step();
        reset_n = 1'b1;
        mem_gnt = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_req", 64'(mr64), 64'd0);

        // 64-bit doubleword and upper-word stores
        mem_gnt = 1'b0;
        store(3'b011, 64'h10, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk("sd_we64", 64'(mw64), 64'hFF);
        chk("sd_wdata64", md64, 64'h1122_3344_5566_7788);
        chk("sd_addr64", ma64, 64'h10);
        store(3'b010, 64'h14, 64'hFFFF_FFFF_DEAD_BEEF);
        mem_gnt = 1'b1;
        step();
        @(negedge clk);
        chk("sw_hi_we64", 64'(mw64), 64'hF0);
        chk("sw_hi_wdata64", md64, 64'hDEAD_BEEF_0000_0000);
        chk("sw_hi_addr64", ma64, 64'h10);
        step();
        step();
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
